cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with a valid/ready handshake on both sides. Operands are split into 4-bit CLA groups; a pipeline register follows every `GPS` groups, so carries ripple group-to-group across stages while generate/propagate lookahead stays inside each group. It serves as the ALU's wide add/sub datapath and extends the 4-bit lookahead adder with arbitrary width, subtraction, flags and back-pressure.

---
 rtl/cla_pipe_addsub.sv | 176 +++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
// Operands are split into 4-bit lookahead groups. Each pipeline stage resolves
// GPS groups and registers the carry, the finished low sum bits and the upper
// operand bits that are not yet consumed. B is stored already conditioned for
// subtraction. Every stage has its own valid bit, and a stall collapses bubbles.
// Optional feature: define CLA_PIPE_FLAGS_EN to build the ovf/zero flags.
// Without it, ovf and zero are tied to 0.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW   = 4 * GPS;
    localparam int NSTG = WIDTH / SW;

    // One 4-bit group with full lookahead. Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic       c1, c2, c3, c4;
        p  = x ^ y;
        g  = x & y;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c4, p ^ {c3, c2, c1, ci}};
    endfunction

    logic [NSTG-1:0] r_v;
    logic [NSTG-1:0] w_ld;

    // A stage may load when it, or any stage after it, has room, or when the output retires.
    always_comb begin : p_ld
        logic acc;
        acc  = out_ready;
        w_ld = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            acc     = acc | ~r_v[k];
            w_ld[k] = acc;
        end
    end

    assign in_ready = w_ld[0];

    // Stage valid bits move forward wherever a stage is allowed to load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else begin
            if (w_ld[0]) r_v[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) begin
                if (w_ld[k]) r_v[k] <= r_v[k-1];
            end
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int HW = WIDTH - SW * k;

        logic [HW-1:0]       w_a;
        logic [HW-1:0]       w_b;
        logic                w_ci;
        logic                w_en;
        logic                w_co;
        logic [SW-1:0]       w_sg;
        logic [SW*(k+1)-1:0] w_sn;
        logic [SW*(k+1)-1:0] r_s;
        logic                r_c;

        if (k == 0) begin : g_src
            assign w_a  = a;
            assign w_b  = sub ? ~b : b;
            assign w_ci = cin ^ sub;
            assign w_en = w_ld[0] & in_valid;
            assign w_sn = w_sg;
        end else begin : g_src
            assign w_a  = g_stg[k-1].g_fwd.r_a;
            assign w_b  = g_stg[k-1].g_fwd.r_b;
            assign w_ci = g_stg[k-1].r_c;
            assign w_en = w_ld[k] & r_v[k-1];
            assign w_sn = {w_sg, g_stg[k-1].r_s};
        end

        // Ripple the carry through this stage's groups. Lookahead stays inside each group.
        always_comb begin : p_grp
            logic c;
            c    = w_ci;
            w_sg = '0;
            for (int j = 0; j < GPS; j++) begin
                {c, w_sg[4*j +: 4]} = cla4(w_a[4*j +: 4], w_b[4*j +: 4], c);
            end
            w_co = c;
        end

        // Capture the partial sum and the carry into the next stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_en) begin
                r_s <= w_sn;
                r_c <= w_co;
            end
        end

        if (k < NSTG - 1) begin : g_fwd
            logic [HW-SW-1:0] r_a;
            logic [HW-SW-1:0] r_b;

            // Carry the operand bits still unconsumed to the following stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a[HW-1:SW];
                    r_b <= w_b[HW-1:SW];
                end
            end
        end
    end

    assign out_valid = r_v[NSTG-1];
    assign sum       = g_stg[NSTG-1].r_s;
    assign cout      = g_stg[NSTG-1].r_c;

`ifdef CLA_PIPE_FLAGS_EN
    logic w_cmsb;
    logic w_ovf;
    logic w_zero;
    logic r_ovf;
    logic r_zero;

    // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
    assign w_cmsb = g_stg[NSTG-1].w_a[SW-1] ^ g_stg[NSTG-1].w_b[SW-1]
                  ^ g_stg[NSTG-1].w_sg[SW-1];
    assign w_ovf  = w_cmsb ^ g_stg[NSTG-1].w_co;
    assign w_zero = (g_stg[NSTG-1].w_sn == '0);

    // Flags are registered together with the final sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (g_stg[NSTG-1].w_en) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign ovf  = r_ovf;
    assign zero = r_zero;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub. An arithmetic reference model plus a queue of
// expected results is checked against the DUT on every sampled cycle.
module tb_cla_pipe_addsub;

    localparam int WIDTH = 16;
    localparam int GPS   = 1;
    localparam int NSTG  = WIDTH / (4 * GPS);
`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf, zero;

    cla_pipe_addsub #(.WIDTH(WIDTH), .GPS(GPS)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c, v, z;
        int               acc;
        bit               lit;
        logic [WIDTH-1:0] ls;
        logic             lc, lv, lz;
    } exp_t;

    exp_t             q[$];
    int               n_vec = 0, n_err = 0, cyc = 0;
    bit               lat_exact = 1'b1, head_seen = 1'b0, stall_prev = 1'b0, last_acc = 1'b0;
    logic [WIDTH-1:0] h_sum;
    logic             h_c, h_v, h_z;
    bit               cur_lit = 1'b0;
    logic [WIDTH-1:0] cur_ls;
    logic             cur_lc, cur_lv, cur_lz;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        exp_t   m;
        longint ux, uy, sx, sy, full, stot, lim;
        lim  = longint'(1) << WIDTH;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = x[WIDTH-1] ? ux - lim : ux;
        sy   = y[WIDTH-1] ? uy - lim : uy;
        if (!sb) begin
            full = ux + uy + longint'(ci);
            stot = sx + sy + longint'(ci);
            m.c  = (full >= lim);
        end else begin
            full = ux - uy - longint'(ci);
            stot = sx - sy - longint'(ci);
            m.c  = (full >= 0);
        end
        m.s   = full[WIDTH-1:0];
        m.v   = FL & ((stot >= lim / 2) || (stot < -(lim / 2)));
        m.z   = FL & (m.s == '0);
        m.acc = 0;
        m.lit = 1'b0;
        m.ls  = '0;
        m.lc  = 1'b0;
        m.lv  = 1'b0;
        m.lz  = 1'b0;
        return m;
    endfunction

    // Called just after a falling edge with inputs set. Checks, updates the model, then advances one cycle.
    task automatic tick();
        exp_t e;
        int   lat;
        #1;
        chk("in_ready", in_ready, (q.size() < NSTG) || out_ready);
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, h_sum);
            chk("hold_flags", {cout, ovf, zero}, {h_c, h_v, h_z});
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                if (!head_seen) begin
                    lat = cyc - q[0].acc;
                    if (lat_exact) chk("latency", lat, NSTG);
                    else           chk("latency_min", lat >= NSTG, 1);
                    head_seen = 1'b1;
                end
                if (out_ready) begin
                    e = q.pop_front();
                    head_seen = 1'b0;
                    chk("sum", sum, e.s);
                    chk("cout", cout, e.c);
                    chk("ovf", ovf, e.v);
                    chk("zero", zero, e.z);
                    if (e.lit) begin
                        chk("lit_sum", sum, e.ls);
                        chk("lit_flags", {cout, ovf, zero}, {e.lc, e.lv, e.lz});
                    end
                end
            end
        end
        stall_prev = out_valid && !out_ready;
        h_sum = sum; h_c = cout; h_v = ovf; h_z = zero;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            e     = model(a, b, cin, sub);
            e.acc = cyc;
            e.lit = cur_lit;
            e.ls  = cur_ls; e.lc = cur_lc; e.lv = cur_lv; e.lz = cur_lz;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_beat();
        logic [WIDTH-1:0] corner[4];
        corner[0] = '0; corner[1] = '1;
        corner[2] = {1'b1, {(WIDTH-1){1'b0}}}; corner[3] = {1'b0, {(WIDTH-1){1'b1}}};
        a   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic send_dir(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic sb, input logic [WIDTH-1:0] ls,
                            input logic lc, input logic lv, input logic lz);
        a = x; b = y; cin = ci; sub = sb;
        cur_lit = 1'b1; cur_ls = ls; cur_lc = lc; cur_lv = lv & FL; cur_lz = lz & FL;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        cur_lit  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, acc_cnt;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 3'b000);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors streamed back-to-back.
        lat_exact = 1'b1;
        send_dir(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1'b0);
        send_dir(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        send_dir(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_dir(16'h0003, 16'h0003, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-pressure: eight beats, output stalled for six cycles.
        lat_exact = 1'b0;
        out_ready = 1'b0;
        sent = 0; acc_cnt = 0;
        rand_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_acc) begin sent++; acc_cnt++; rand_beat(); end
        end
        chk("bp_accepts", acc_cnt, NSTG);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sent < 8; i++) begin
            tick();
            if (last_acc) begin sent++; rand_beat(); end
        end
        chk("bp_sent", sent, 8);
        drain();

        // Reset with three beats in flight.
        lat_exact = 1'b1;
        sent = 0;
        rand_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 20 && sent < 3; i++) begin
            tick();
            if (last_acc) begin sent++; rand_beat(); end
        end
        in_valid = 1'b0;
        chk("rst_inflight", q.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_flags", {cout, ovf, zero}, 3'b000);
        q.delete();
        head_seen = 1'b0; stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Random stream with random back-pressure.
        lat_exact = 1'b0;
        sent = 0;
        rand_beat();
        for (int i = 0; i < 20000 && sent < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            if (last_acc) begin sent++; rand_beat(); end
        end
        chk("rand_sent", sent, 3000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
